// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared widths, shift direction/type encodings and output-stage states for shift_arbiter
package shift_arb_pkg;
  localparam int DATA_W = 8;
  localparam int SHAMT_W = 3;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic SH_LOGIC = 1'b0;
  localparam logic SH_ARITH = 1'b1;
  typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational 8-bit shifter (din, shamt, lr 0=left/1=right, al 0=logical/1=arithmetic -> dout)
module shift_core
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0]  din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               lr,
  input  logic               al,
  output logic [DATA_W-1:0]  dout
);
  logic fill;
  logic [2*DATA_W-1:0] ext;
  always_comb begin
    fill = (lr == DIR_RIGHT) && (al == SH_ARITH) && din[DATA_W-1];
    ext = {{DATA_W{fill}}, din} >> shamt;
    dout = (lr == DIR_RIGHT) ? ext[DATA_W-1:0] : din << shamt;
  end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one shift_core among NREQ valid/ready requesters into a 1-entry resp stage (clk, rst, req_valid/ready/din/shamt/lr/al, resp_valid/ready/id/dout; stat_grant_cnt when SHIFT_ARB_STATS_EN is defined)
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATA_W-1:0]    req_din,
  input  logic [NREQ*SHAMT_W-1:0]   req_shamt,
  input  logic [NREQ-1:0]           req_lr,
  input  logic [NREQ-1:0]           req_al,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_dout
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]        stat_grant_cnt
`endif
);
  out_state_t st;
  logic [ID_W-1:0] rr_ptr, win;
  logic found, can_accept, xfer;
  logic [DATA_W-1:0] sh;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = ID_W'((int'(rr_ptr) + k) % NREQ);
      end
  end
  assign resp_valid = st == FULL;
  assign can_accept = !resp_valid || resp_ready;
  assign req_ready = (found && can_accept && !rst) ? NREQ'(1) << win : '0;
  assign xfer = |req_ready;
  shift_core u_core (
    .din  (req_din[int'(win)*DATA_W +: DATA_W]),
    .shamt(req_shamt[int'(win)*SHAMT_W +: SHAMT_W]),
    .lr   (req_lr[win]),
    .al   (req_al[win]),
    .dout (sh)
  );
  always_ff @(posedge clk)
    if (rst) begin
      st <= EMPTY;
      resp_dout <= '0;
      resp_id <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      st <= FULL;
      resp_dout <= sh;
      resp_id <= win;
      rr_ptr <= (win == ID_W'(NREQ - 1)) ? '0 : win + ID_W'(1);
    end else if (resp_ready) st <= EMPTY;
`ifdef SHIFT_ARB_STATS_EN
  always_ff @(posedge clk)
    for (int i = 0; i < NREQ; i++)
      if (rst) stat_grant_cnt[i*16 +: 16] <= '0;
      else if (req_ready[i] && stat_grant_cnt[i*16 +: 16] != 16'hFFFF)
        stat_grant_cnt[i*16 +: 16] <= stat_grant_cnt[i*16 +: 16] + 16'd1;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: table vectors, directed corner sequences and randomized traffic against a behavioural model
module tb_shift_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_lr = '0, req_al = '0;
  logic [N*8-1:0] req_din = '0;
  logic [N*3-1:0] req_shamt = '0;
  logic resp_valid, resp_ready = 1'b1;
  logic [1:0] resp_id;
  logic [7:0] resp_dout;
`ifdef SHIFT_ARB_STATS_EN
  logic [N*16-1:0] stat_grant_cnt;
`endif
  shift_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_din(req_din), .req_shamt(req_shamt), .req_lr(req_lr), .req_al(req_al),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_dout(resp_dout)
`ifdef SHIFT_ARB_STATS_EN
    , .stat_grant_cnt(stat_grant_cnt)
`endif
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic vld [N];
  logic [7:0] din [N];
  int shamt [N];
  logic lr [N], al [N];
  logic m_valid = 1'b0;
  logic [7:0] m_dout = '0;
  int m_id = 0, m_ptr = 0;
  typedef struct {logic [7:0] din; int shamt; logic lr; logic al; logic [7:0] exp;} vec_t;
  vec_t vt [8];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [7:0] ref_shift(logic [7:0] d, int s, logic r, logic a);
    if (!r) return 8'(d << s);
    if (a) return 8'($signed(d) >>> s);
    return d >> s;
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = vld[i];
      req_din[8*i +: 8] = din[i];
      req_shamt[3*i +: 3] = 3'(shamt[i]);
      req_lr[i] = lr[i];
      req_al[i] = al[i];
    end
  endtask
  // one clock: check req_ready against the model, advance the model at the edge, check resp outputs
  task automatic cycle(output int g);
    logic [N-1:0] er;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = (!rst && g >= 0 && (!m_valid || resp_ready)) ? N'(1) << g : '0;
    if (er == 0) g = -1;
    chk("req_ready", req_ready, er);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_dout = '0; m_id = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_dout = ref_shift(din[g], shamt[g], lr[g], al[g]); m_id = g; m_ptr = (g + 1) % N;
    end else if (resp_ready) m_valid = 1'b0;
    #1;
    chk("resp_valid", resp_valid, m_valid);
    chk("resp_id", resp_id, m_id);
    chk("resp_dout", resp_dout, m_dout);
  endtask
  initial begin
    int g;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b1; din[i] = 8'(8'h10 * (i + 1) + i); shamt[i] = i + 1; lr[i] = i[0]; al[i] = i[1];
    end
    vt[0] = '{8'hB4, 2, 1'b1, 1'b1, 8'hED};
    vt[1] = '{8'hB4, 2, 1'b1, 1'b0, 8'h2D};
    vt[2] = '{8'h81, 1, 1'b0, 1'b0, 8'h02};
    vt[3] = '{8'h81, 1, 1'b0, 1'b1, 8'h02};
    vt[4] = '{8'h81, 0, 1'b0, 1'b0, 8'h81};
    vt[5] = '{8'h80, 7, 1'b1, 1'b1, 8'hFF};
    vt[6] = '{8'h7F, 7, 1'b1, 1'b1, 8'h00};
    vt[7] = '{8'h01, 7, 1'b0, 1'b1, 8'h80};
    @(posedge clk); #1;
    cycle(g);
    cycle(g);
    rst = 1'b0;
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    cycle(g);
    for (int v = 0; v < 8; v++) begin
      vld[0] = 1'b1; din[0] = vt[v].din; shamt[0] = vt[v].shamt; lr[0] = vt[v].lr; al[0] = vt[v].al;
      cycle(g);
      chk("vec_dout", resp_dout, vt[v].exp);
      chk("vec_id", resp_id, 0);
      vld[0] = 1'b0;
      cycle(g);
    end
    rst = 1'b1; cycle(g); rst = 1'b0;
    for (int i = 0; i < N; i++) vld[i] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle(g);
      chk("rr_order", g, c % N);
      chk("rr_id", resp_id, c % N);
    end
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle(g);
    chk("bp_id", resp_id, 3);
    resp_ready = 1'b1;
    cycle(g);
    chk("bp_release", g, 0);
    chk("bp_valid", resp_valid, 1);
    resp_ready = 1'b0;
    cycle(g);
    rst = 1'b1;
    cycle(g);
    chk("rst_valid", resp_valid, 0);
    chk("rst_dout", resp_dout, 0);
    rst = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0; resp_ready = 1'b1;
    cycle(g);
    chk("post_rst_grant", g, 2);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1; din[i] = 8'($urandom); shamt[i] = $urandom_range(0, 7);
          lr[i] = 1'($urandom); al[i] = 1'($urandom);
        end
      resp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 60) == 0);
      cycle(g);
      if (g >= 0) vld[g] = 1'b0;
    end
    rst = 1'b0; resp_ready = 1'b1;
`ifdef SHIFT_ARB_STATS_EN
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    rst = 1'b1; cycle(g); rst = 1'b0;
    vld[2] = 1'b1;
    for (int c = 0; c < 5; c++) cycle(g);
    vld[2] = 1'b0; vld[0] = 1'b1;
    cycle(g);
    vld[0] = 1'b0;
    cycle(g);
    chk("stat2", stat_grant_cnt[32 +: 16], 5);
    chk("stat0", stat_grant_cnt[0 +: 16], 1);
    vld[0] = 1'b1;
    drive();
    repeat (65540) @(posedge clk);
    #1;
    chk("stat_sat", stat_grant_cnt[0 +: 16], 16'hFFFF);
    chk("stat2_hold", stat_grant_cnt[32 +: 16], 5);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
